// File: rtl/gpr_file_sb_if.sv
// -----------------------------------------------------------------------------
// gpr_file_sb_if
//
// Bundles the read, issue and writeback signals of the GPR file with its
// scoreboard.
//
// Modports:
//   master : decode/writeback side. It drives the read addresses, the issue
//            and the writeback, and it receives the read data, busy flags,
//            hazard and the scoreboard vector.
//   slave  : the register file (gpr_file_sb).
//
// Signal semantics:
//   - There is no ready/back-pressure.
//   - issue_valid and wb_valid are single-cycle strobes. The register file
//     accepts them unconditionally at the rising clock edge where they are
//     high.
//   - rd_en does not gate data. It only qualifies whether a busy read port
//     contributes to hazard.
//
// Parameters:
//   DATA_W : register width in bits.
//   NREGS  : number of registers (power of two, >= 2).
//   NRD    : number of read ports (1..4).
// -----------------------------------------------------------------------------
interface gpr_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2
);
  localparam int AW = $clog2(NREGS);

  // Read side (decode)
  logic [NRD-1:0]        rd_en;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  hazard;

  // Issue side (decode marks a destination as pending)
  logic                  issue_valid;
  logic [AW-1:0]         issue_dst;

  // Writeback side
  logic                  wb_valid;
  logic [AW-1:0]         wb_addr;
  logic [DATA_W-1:0]     wb_data;

  // Scoreboard state for debug/verification
  logic [NREGS-1:0]      busy_vec;

  modport master (
    output rd_en, rd_addr, issue_valid, issue_dst, wb_valid, wb_addr, wb_data,
    input  rd_data, rd_busy, hazard, busy_vec
  );

  modport slave (
    input  rd_en, rd_addr, issue_valid, issue_dst, wb_valid, wb_addr, wb_data,
    output rd_data, rd_busy, hazard, busy_vec
  );
endinterface

// File: rtl/gpr_file_sb.sv
// -----------------------------------------------------------------------------
// gpr_file_sb
//
// General-purpose register file with an integrated write-pending scoreboard.
// It provides:
//   - NRD combinational read ports.
//   - One synchronous writeback port.
//   - One busy bit per register, so decode can detect RAW hazards.
// Register 0 always reads zero, ignores writes and is never marked busy.
//
// Ports:
//   clk : rising-edge clock.
//   rst : synchronous, active-high reset. It clears every register and every
//         busy bit, and it overrides a simultaneous issue or writeback.
//   bus : gpr_file_sb_if.slave, which carries:
//     rd_en/rd_addr/rd_data/rd_busy/hazard : read ports and hazard detect.
//     issue_valid/issue_dst                : mark a destination pending.
//     wb_valid/wb_addr/wb_data             : write a value and clear pending.
//     busy_vec                             : scoreboard state (debug).
//
// Build option:
//   GPR_BYPASS_EN (macro). When defined, a read of the register being written
//   back in the same cycle returns wb_data and reports not-busy. When
//   undefined, reads see the stored value and the stored busy bit, and the
//   new value becomes visible one cycle later.
// -----------------------------------------------------------------------------
module gpr_file_sb #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2
) (
  input logic         clk,
  input logic         rst,
  gpr_file_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] gpr_q [NREGS];
  logic [DATA_W-1:0] gpr_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  logic wb_fire;
  logic issue_fire;

  // Address 0 is hard-wired. Filtering it here keeps both the storage and the
  // scoreboard update free of special cases.
  assign wb_fire    = bus.wb_valid    && (bus.wb_addr   != '0);
  assign issue_fire = bus.issue_valid && (bus.issue_dst != '0);

  // ---------------------------------------------------------------------------
  // Next-state: storage and scoreboard
  // ---------------------------------------------------------------------------
  always_comb begin
    gpr_d  = gpr_q;
    busy_d = busy_q;

    if (wb_fire) begin
      gpr_d[bus.wb_addr]  = bus.wb_data;
      busy_d[bus.wb_addr] = 1'b0;
    end

    // The issue is applied after the writeback. When both target the same
    // register in one cycle, the new pending write wins. An issue to a
    // register that is already busy simply leaves it set: only one write per
    // register may be in flight.
    if (issue_fire) begin
      busy_d[bus.issue_dst] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        gpr_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        gpr_q[r] <= gpr_d[r];
      end
      busy_q <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [AW-1:0]         rd_addr_a [NRD];
  logic [NRD-1:0]        byp;
  logic [NRD*DATA_W-1:0] rd_data_w;
  logic [NRD-1:0]        rd_busy_w;
  logic                  hazard_w;

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_addr_a[i] = bus.rd_addr[i*AW +: AW];
    end
  end

  // Bypass match per port. wb_fire already excludes register 0, so reads of
  // r0 never pick up wb_data.
  always_comb begin
    byp = '0;
`ifdef GPR_BYPASS_EN
    for (int i = 0; i < NRD; i++) begin
      byp[i] = wb_fire && (bus.wb_addr == rd_addr_a[i]);
    end
`endif
  end

  always_comb begin
    rd_data_w = '0;
    rd_busy_w = '0;
    hazard_w  = 1'b0;
    // While rst is high, all read-side outputs are held at zero. This also
    // covers the cycle before the first reset edge has cleared the storage.
    if (!rst) begin
      for (int i = 0; i < NRD; i++) begin
        if (byp[i]) begin
          rd_data_w[i*DATA_W +: DATA_W] = bus.wb_data;
          rd_busy_w[i]                  = 1'b0;
        end else begin
          if (rd_addr_a[i] != '0) begin
            rd_data_w[i*DATA_W +: DATA_W] = gpr_q[rd_addr_a[i]];
          end
          rd_busy_w[i] = busy_q[rd_addr_a[i]];
        end
        hazard_w = hazard_w | (bus.rd_en[i] & rd_busy_w[i]);
      end
    end
  end

  assign bus.rd_data  = rd_data_w;
  assign bus.rd_busy  = rd_busy_w;
  assign bus.hazard   = hazard_w;
  assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_gpr_file_sb.sv
// -----------------------------------------------------------------------------
// tb_gpr_file_sb
//
// Directed testbench for gpr_file_sb (DATA_W=32, NREGS=32, NRD=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 time
// unit after that. Expected values are hand-computed constants. The bypass
// expectations follow the GPR_BYPASS_EN macro of the build.
// -----------------------------------------------------------------------------
module tb_gpr_file_sb;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int NRD    = 2;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  gpr_file_sb_if #(.DATA_W(DATA_W), .NREGS(NREGS), .NRD(NRD)) bus ();

  gpr_file_sb #(.DATA_W(DATA_W), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd_en       = '0;
    bus.rd_addr     = '0;
    bus.issue_valid = 1'b0;
    bus.issue_dst   = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
  endtask

  task automatic drive_wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = a;
    bus.wb_data  = d;
  endtask

  task automatic drive_issue(input logic [4:0] a);
    bus.issue_valid = 1'b1;
    bus.issue_dst   = a;
  endtask

  task automatic drive_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] en);
    bus.rd_addr = {a1, a0};
    bus.rd_en   = en;
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (bus.busy_vec !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_busy_vec got=%h exp=%h", bus.busy_vec, 32'h0);
    end
    n_tests++;
    if (bus.rd_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_rd_data got=%h exp=%h", bus.rd_data, 64'h0);
    end
    // Preload r5 and mark r6 pending.
    rst = 1'b0;
    drive_wb(5'd5, 32'h0000_1234);
    drive_issue(5'd6);
    tick();
    idle();
    drive_rd(5'd5, 5'd6, 2'b11);
    settle();
    n_tests++;
    if (bus.rd_data[31:0] !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL preload_r5 got=%h exp=%h", bus.rd_data[31:0], 32'h0000_1234);
    end
    n_tests++;
    if (bus.busy_vec !== 32'h0000_0040 || bus.hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL preload_busy got=%h/%b exp=%h/1", bus.busy_vec, bus.hazard, 32'h0000_0040);
    end
    // A reset with a simultaneous issue and writeback: the reset wins.
    rst = 1'b1;
    drive_issue(5'd7);
    drive_wb(5'd8, 32'hFFFF_FFFF);
    tick();
    rst = 1'b0;
    idle();
    drive_rd(5'd5, 5'd8, 2'b11);
    settle();
    n_tests++;
    if (bus.rd_data !== 64'h0 || bus.busy_vec !== 32'h0 || bus.hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clears got data=%h busy=%h hz=%b exp 0/0/0", bus.rd_data, bus.busy_vec, bus.hazard);
    end
    drive_rd(5'd6, 5'd7, 2'b11);
    settle();
    n_tests++;
    if (bus.rd_busy !== 2'b00 || bus.hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rd_busy got=%b/%b exp=00/0", bus.rd_busy, bus.hazard);
    end
  endtask

  task automatic test_write_read();
    idle();
    drive_wb(5'd1, 32'h0000_03E8);
    tick();
    idle();
    drive_rd(5'd1, 5'd1, 2'b00);
    settle();
    n_tests++;
    if (bus.rd_data !== {32'h0000_03E8, 32'h0000_03E8}) begin
      n_fail++;
      $display("FAIL write_read_r1 got=%h exp=%h", bus.rd_data, {32'h0000_03E8, 32'h0000_03E8});
    end
    drive_wb(5'd0, 32'hDEAD_BEEF);
    tick();
    idle();
    drive_rd(5'd0, 5'd1, 2'b00);
    settle();
    n_tests++;
    if (bus.rd_data !== {32'h0000_03E8, 32'h0000_0000}) begin
      n_fail++;
      $display("FAIL write_r0_ignored got=%h exp=%h", bus.rd_data, {32'h0000_03E8, 32'h0000_0000});
    end
  endtask

  task automatic test_scoreboard();
    idle();
    drive_issue(5'd2);
    tick();
    idle();
    drive_rd(5'd2, 5'd0, 2'b01);
    settle();
    n_tests++;
    if (bus.rd_busy[0] !== 1'b1 || bus.hazard !== 1'b1 || bus.busy_vec !== 32'h0000_0004) begin
      n_fail++;
      $display("FAIL sb_issue got rb=%b hz=%b bv=%h exp 1/1/%h", bus.rd_busy[0], bus.hazard, bus.busy_vec, 32'h4);
    end
    // rd_en low: still busy, but no hazard.
    drive_rd(5'd2, 5'd0, 2'b00);
    settle();
    n_tests++;
    if (bus.rd_busy[0] !== 1'b1 || bus.hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_rd_en_gate got rb=%b hz=%b exp 1/0", bus.rd_busy[0], bus.hazard);
    end
    // The busy flag reaches the port-1 hazard path as well.
    drive_rd(5'd0, 5'd2, 2'b10);
    settle();
    n_tests++;
    if (bus.rd_busy !== 2'b10 || bus.hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_port1 got rb=%b hz=%b exp 10/1", bus.rd_busy, bus.hazard);
    end
    drive_wb(5'd2, 32'h0000_0005);
    tick();
    idle();
    drive_rd(5'd2, 5'd2, 2'b11);
    settle();
    n_tests++;
    if (bus.busy_vec !== 32'h0 || bus.hazard !== 1'b0 || bus.rd_data !== {32'h5, 32'h5}) begin
      n_fail++;
      $display("FAIL sb_wb_clear got bv=%h hz=%b d=%h exp 0/0/%h", bus.busy_vec, bus.hazard, bus.rd_data, {32'h5, 32'h5});
    end
  endtask

  task automatic test_simultaneous();
    idle();
    drive_issue(5'd3);
    tick();
    idle();
    // Issue and writeback of r3 in the same cycle: r3 stays busy.
    drive_issue(5'd3);
    drive_wb(5'd3, 32'h0000_0077);
    tick();
    idle();
    drive_rd(5'd3, 5'd0, 2'b01);
    settle();
    n_tests++;
    if (bus.busy_vec !== 32'h0000_0008 || bus.rd_data[31:0] !== 32'h0000_0077) begin
      n_fail++;
      $display("FAIL simul_issue_wb got bv=%h d=%h exp %h/%h", bus.busy_vec, bus.rd_data[31:0], 32'h8, 32'h77);
    end
    // An issue to an already-busy register does not count. A writeback to a
    // non-busy register leaves its busy bit clear.
    drive_issue(5'd3);
    drive_wb(5'd9, 32'h0000_0099);
    tick();
    idle();
    drive_wb(5'd3, 32'h0000_0033);
    tick();
    idle();
    drive_rd(5'd3, 5'd9, 2'b11);
    settle();
    n_tests++;
    if (bus.busy_vec !== 32'h0 || bus.rd_data !== {32'h0000_0099, 32'h0000_0033} || bus.hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_no_count got bv=%h d=%h hz=%b exp 0/%h/0", bus.busy_vec, bus.rd_data, bus.hazard,
               {32'h0000_0099, 32'h0000_0033});
    end
  endtask

  task automatic test_bypass();
    idle();
    drive_wb(5'd4, 32'h0BAD_F00D);
    tick();
    idle();
    drive_issue(5'd4);
    tick();
    idle();
    drive_wb(5'd4, 32'hA5A5_A5A5);
    drive_rd(5'd4, 5'd4, 2'b11);
    settle();
`ifdef GPR_BYPASS_EN
    n_tests++;
    if (bus.rd_data !== {32'hA5A5_A5A5, 32'hA5A5_A5A5} || bus.rd_busy !== 2'b00 || bus.hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_same_cycle got d=%h rb=%b hz=%b exp %h/00/0", bus.rd_data, bus.rd_busy, bus.hazard,
               {32'hA5A5_A5A5, 32'hA5A5_A5A5});
    end
`else
    n_tests++;
    if (bus.rd_data !== {32'h0BAD_F00D, 32'h0BAD_F00D} || bus.rd_busy !== 2'b11 || bus.hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL nobypass_same_cycle got d=%h rb=%b hz=%b exp %h/11/1", bus.rd_data, bus.rd_busy, bus.hazard,
               {32'h0BAD_F00D, 32'h0BAD_F00D});
    end
`endif
    n_tests++;
    if (bus.busy_vec !== 32'h0000_0010) begin
      n_fail++;
      $display("FAIL bypass_busy_vec got=%h exp=%h", bus.busy_vec, 32'h10);
    end
    tick();
    idle();
    drive_rd(5'd4, 5'd4, 2'b11);
    settle();
    n_tests++;
    if (bus.rd_data !== {32'hA5A5_A5A5, 32'hA5A5_A5A5} || bus.rd_busy !== 2'b00 || bus.busy_vec !== 32'h0) begin
      n_fail++;
      $display("FAIL bypass_after got d=%h rb=%b bv=%h exp %h/00/0", bus.rd_data, bus.rd_busy, bus.busy_vec,
               {32'hA5A5_A5A5, 32'hA5A5_A5A5});
    end
    // A writeback to r0 never bypasses into a read of r0.
    drive_wb(5'd0, 32'h1234_5678);
    drive_rd(5'd0, 5'd4, 2'b11);
    settle();
    n_tests++;
    if (bus.rd_data[31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL bypass_r0 got=%h exp=%h", bus.rd_data[31:0], 32'h0);
    end
    tick();
    idle();
  endtask

  task automatic test_r0_issue();
    idle();
    drive_issue(5'd0);
    tick();
    idle();
    drive_rd(5'd0, 5'd0, 2'b11);
    settle();
    n_tests++;
    if (bus.busy_vec !== 32'h0 || bus.rd_busy !== 2'b00 || bus.hazard !== 1'b0 || bus.rd_data !== 64'h0) begin
      n_fail++;
      $display("FAIL r0_issue got bv=%h rb=%b hz=%b d=%h exp 0/00/0/0", bus.busy_vec, bus.rd_busy, bus.hazard, bus.rd_data);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    drive_wb(5'd10, 32'h1111_0000);
    drive_issue(5'd31);
    tick();
    drive_wb(5'd11, 32'h2222_0000);
    drive_issue(5'd12);
    tick();
    drive_wb(5'd31, 32'h3333_FFFF);
    bus.issue_valid = 1'b0;
    tick();
    idle();
    drive_rd(5'd10, 5'd11, 2'b11);
    settle();
    n_tests++;
    if (bus.rd_data !== {32'h2222_0000, 32'h1111_0000}) begin
      n_fail++;
      $display("FAIL b2b_r10_r11 got=%h exp=%h", bus.rd_data, {32'h2222_0000, 32'h1111_0000});
    end
    drive_rd(5'd31, 5'd12, 2'b11);
    settle();
    n_tests++;
    if (bus.rd_data[31:0] !== 32'h3333_FFFF || bus.busy_vec !== 32'h0000_1000 || bus.rd_busy !== 2'b10 ||
        bus.hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_r31_r12 got d=%h bv=%h rb=%b hz=%b exp %h/%h/10/1", bus.rd_data[31:0], bus.busy_vec,
               bus.rd_busy, bus.hazard, 32'h3333_FFFF, 32'h1000);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_scoreboard();
    test_simultaneous();
    test_bypass();
    test_r0_issue();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_file_sb.md
# gpr_file_sb

Parametrised general-purpose register file with an integrated write-pending scoreboard, the next generation of the mini-MIPS GPR array. It provides NRD combinational read ports, one synchronous writeback port, optional write-to-read bypass, and per-register busy tracking so the decode stage can detect RAW hazards. It sits between decode (read/issue) and writeback in the mini-MIPS datapath.

## Interface
- DATA_W, 32, register width in bits
- NREGS, 32, number of registers (power of two, ≥2); AW = $clog2(NREGS)
- NRD, 2, number of read ports (1–4)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- rd_en  input  NRD  per-port read request (only qualifies hazard)
- rd_addr  input  NRD*AW  packed read addresses, port i at [i*AW +: AW]
- rd_data  output  NRD*DATA_W  packed read data
- rd_busy  output  NRD  per-port: addressed register has a pending write
- hazard  output  1  OR over i of (rd_en[i] & rd_busy[i])
- issue_valid  input  1  an instruction with a destination is issued this cycle
- issue_dst  input  AW  destination register of issued instruction
- wb_valid  input  1  writeback this cycle
- wb_addr  input  AW  writeback register
- wb_data  input  DATA_W  writeback value
- busy_vec  output  NREGS  current scoreboard state (debug/verification)

## Operation
- Storage: GPR[0..NREGS-1], DATA_W bits each. GPR[0] reads 0 always; writes to 0 are ignored; register 0 is never marked busy.
- Write: on rising clk with wb_valid and wb_addr≠0, GPR[wb_addr] <= wb_data.
- Read: rd_data port i = GPR[rd_addr_i] combinationally (0 when address 0); bypass rules under Configuration.
- Scoreboard busy[r], one bit per register:
  - issue_valid & issue_dst≠0: busy[issue_dst] <= 1.
  - wb_valid & wb_addr≠0: busy[wb_addr] <= 0.
  - Same register issued and written back in one cycle: busy stays 1 (new pending write wins).
  - Issue to already-busy register: stays 1 (no count; one in-flight write per register is the pipeline contract).
  - Writeback to non-busy register: data written, busy stays 0.
- rd_busy[i] = busy[rd_addr_i] & ~(wb_valid & wb_addr==rd_addr_i & bypass enabled); without bypass it is busy[rd_addr_i] unmasked.
- hazard is combinational; decode stalls when asserted.

## Timing
- Reset (rst high at clk edge): all GPR <= 0, all busy <= 0. During and after reset rd_data = 0, rd_busy = 0, hazard = 0, busy_vec = 0. Reset overrides simultaneous issue/wb.
- Write latency: 1 cycle; value visible on reads in the cycle after the wb edge (or same cycle with bypass).
- Busy set: visible the cycle after issue edge. Busy clear: visible the cycle after wb edge.
- Reads: zero-latency, combinational from rd_addr.
- Multiple read ports to the same address return identical data and busy.
- Reset mid-operation discards pending writes; no writeback after reset is required for busy to be 0.

## Configuration
- GPR_BYPASS_EN defined: when wb_valid & wb_addr==rd_addr_i & wb_addr≠0, rd_data port i = wb_data and rd_busy[i] = 0 in that same cycle.
- GPR_BYPASS_EN undefined: reads return the stored (pre-write) value during the writeback cycle; rd_busy[i] reflects the stored busy bit; consumer sees new data one cycle later.

## Test plan
- Reset: preload via wb, assert rst one cycle -> all rd_data = 0, busy_vec = 0, hazard = 0 next cycle.
- Write/read: wb r1 = 32'h000003E8, next cycle read r1 on port 0 and r1 on port 1 -> both 32'h000003E8; wb r0 = 32'hDEADBEEF -> r0 reads 0.
- Scoreboard: issue r2, next cycle rd_en[0]=1 rd_addr=2 -> rd_busy[0]=1, hazard=1; wb r2 = 32'h5 -> cycle after, busy_vec[2]=0, hazard=0, data 32'h5.
- Simultaneous: r3 busy; same cycle issue_dst=3 and wb_addr=3 -> busy_vec[3] remains 1 after edge, GPR[3] updated.
- Bypass (with GPR_BYPASS_EN): r4 busy, wb r4 = 32'hA5A5A5A5 while reading r4 -> same cycle rd_data=32'hA5A5A5A5, rd_busy=0; without macro -> old value, rd_busy=1.
- Issue r0 -> busy_vec stays 0, no hazard on reads of r0.
